// File: rtl/gate_unit_arbiter_if.sv
// Bundles the requester-side and result-side signals of gate_unit_arbiter.
// The arbiter uses the slave modport; requesters and the result consumer
// together use the master modport.
interface gate_unit_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [2:0]            res_op;
  logic [WIDTH-1:0]      res_data;
  logic                  res_ready;

  modport master (
    output req, req_op, req_a, req_b, res_ready,
    input  gnt, res_valid, res_id, res_op, res_data
  );

  modport slave (
    input  req, req_op, req_a, req_b, res_ready,
    output gnt, res_valid, res_id, res_op, res_data
  );
endinterface

// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter: shares one WIDTH-bit basic-gate unit between NREQ
// requesters with round-robin arbitration and a single valid/ready result
// register.
// Optional feature macro: GATE_ARB_PRIO0_EN -- when defined, requester 0 has
// fixed top priority and the rest round-robin among themselves.
//
// Result register FSM:
//   state | meaning
//   EMPTY | no result held, res_valid=0, any request may be accepted
//   FULL  | result held, res_valid=1, reload only when consumer takes it
module gate_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  gate_unit_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_next;
  logic [IDW-1:0]   ptr, ptr_next;
  logic [IDW-1:0]   win;
  logic [IDW:0]     sum;
  logic [IDW-1:0]   idx;
  logic             found;
  logic             accept;
  logic             grant;
  logic [NREQ-1:0]  gnt_vec;
  logic [2:0]       op_arr [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];
  logic [IDW-1:0]   res_id;
  logic [2:0]       res_op;
  logic [WIDTH-1:0] res_data;

  function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~a;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = a ^ b;
      3'd6:    r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Unpack the flat requester buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = bus.req_op[3*i +: 3];
      a_arr[i]  = bus.req_a[WIDTH*i +: WIDTH];
      b_arr[i]  = bus.req_b[WIDTH*i +: WIDTH];
    end
  end

  // Pick the winner: first pending request searching upward from ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
`ifdef GATE_ARB_PRIO0_EN
    // Requester 0 pre-empts the rotating search; the search itself never
    // selects 0 when req[0] is low, so the others rotate among themselves.
    if (bus.req[0]) found = 1'b1;
`endif
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign ptr_next = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;

  // Result register state.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Accept/grant decision and next result-register state.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    gnt_vec    = '0;
    accept     = (state == EMPTY) || bus.res_ready;
    if (!rst && accept && found) begin
      grant        = 1'b1;
      gnt_vec[win] = 1'b1;
    end
    case (state)
      EMPTY:   if (grant) state_next = FULL;
      FULL:    if (bus.res_ready && !grant) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Load the result of the granted request; hold it otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_id   <= '0;
      res_op   <= '0;
      res_data <= '0;
    end else if (grant) begin
      res_id   <= win;
      res_op   <= op_arr[win];
      res_data <= gate_eval(op_arr[win], a_arr[win], b_arr[win]);
    end
  end

  // Advance the round-robin pointer past the last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant) begin
`ifdef GATE_ARB_PRIO0_EN
      if (win != '0) ptr <= ptr_next;
`else
      ptr <= ptr_next;
`endif
    end
  end

  assign bus.gnt       = gnt_vec;
  assign bus.res_valid = (state == FULL);
  assign bus.res_id    = res_id;
  assign bus.res_op    = res_op;
  assign bus.res_data  = res_data;
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter (NREQ=4, WIDTH=8).
module tb_gate_unit_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  gate_unit_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  gate_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_op[3*i +: 3]         = op;
    bus.req_a[WIDTH*i +: WIDTH]  = a;
    bus.req_b[WIDTH*i +: WIDTH]  = b;
  endtask

  logic [3:0] fair_gnt [5];
  logic [1:0] fair_id  [5];
  logic [7:0] fair_dat [4];
  logic [7:0] sweep    [8];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    fair_dat = '{8'h0A, 8'hAF, 8'h55, 8'hF5};
    sweep    = '{8'h0A, 8'hAF, 8'h55, 8'hF5, 8'h50, 8'hA5, 8'h5A, 8'h00};
`ifdef GATE_ARB_PRIO0_EN
    fair_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    fair_id  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    fair_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fair_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif

    // Reset, with requests pending so the gnt masking is visible.
    rst           = 1'b1;
    bus.req       = 4'b1111;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    tick();
    tick();
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_valid", 32'(bus.res_valid), 32'h0);
    check("rst_data", 32'(bus.res_data), 32'h0);
    check("rst_id", 32'(bus.res_id), 32'h0);
    check("rst_op", 32'(bus.res_op), 32'h0);
    bus.req = '0;
    rst     = 1'b0;
    tick();

    // Single XOR on requester 0.
    set_req(0, 3'd5, 8'hF0, 8'h3C);
    bus.req = 4'b0001;
    #1;
    check("single_gnt", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = '0;
    check("single_valid", 32'(bus.res_valid), 32'h1);
    check("single_id", 32'(bus.res_id), 32'h0);
    check("single_data", 32'(bus.res_data), 32'hCC);
    check("single_op", 32'(bus.res_op), 32'h5);
    tick();
    check("drain_valid", 32'(bus.res_valid), 32'h0);

    // Fairness from a fresh pointer, all requesters busy.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 8'hAA, 8'h0F);
    bus.req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("fair_gnt%0d", c), 32'(bus.gnt), 32'(fair_gnt[c]));
      tick();
      check($sformatf("fair_valid%0d", c), 32'(bus.res_valid), 32'h1);
      check($sformatf("fair_id%0d", c), 32'(bus.res_id), 32'(fair_id[c]));
      check($sformatf("fair_data%0d", c), 32'(bus.res_data), 32'(fair_dat[fair_id[c]]));
    end
    bus.req = '0;
    tick();
    check("fair_drain", 32'(bus.res_valid), 32'h0);

    // Backpressure: fill with ready low, then hold.
    bus.res_ready = 1'b0;
    set_req(1, 3'd0, 8'hAA, 8'h0F);
    bus.req = 4'b0010;
    #1;
    check("bp_fill_gnt", 32'(bus.gnt), 32'h2);
    tick();
    check("bp_fill_valid", 32'(bus.res_valid), 32'h1);
    check("bp_fill_data", 32'(bus.res_data), 32'h0A);
    set_req(1, 3'd4, 8'hAA, 8'h0F);
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("bp_gnt%0d", c), 32'(bus.gnt), 32'h0);
      tick();
      check($sformatf("bp_valid%0d", c), 32'(bus.res_valid), 32'h1);
      check($sformatf("bp_data%0d", c), 32'(bus.res_data), 32'h0A);
      check($sformatf("bp_id%0d", c), 32'(bus.res_id), 32'h1);
      check($sformatf("bp_op%0d", c), 32'(bus.res_op), 32'h0);
    end
    bus.res_ready = 1'b1;
    #1;
    check("bp_release_gnt", 32'(bus.gnt), 32'h2);
    tick();
    check("bp_new_valid", 32'(bus.res_valid), 32'h1);
    check("bp_new_data", 32'(bus.res_data), 32'h50);
    check("bp_new_op", 32'(bus.res_op), 32'h4);
    bus.req = '0;
    tick();
    check("bp_drain", 32'(bus.res_valid), 32'h0);

    // Op sweep on requester 2, back to back.
    bus.req = 4'b0100;
    for (int op = 0; op < 8; op++) begin
      set_req(2, 3'(op), 8'hAA, 8'h0F);
      #1;
      check($sformatf("sweep_gnt%0d", op), 32'(bus.gnt), 32'h4);
      tick();
      check($sformatf("sweep_data%0d", op), 32'(bus.res_data), 32'(sweep[op]));
      check($sformatf("sweep_op%0d", op), 32'(bus.res_op), 32'(op));
      check($sformatf("sweep_id%0d", op), 32'(bus.res_id), 32'h2);
    end

    // Reset while FULL discards the result and rewinds the pointer.
    bus.req = '0;
    rst     = 1'b1;
    tick();
    check("midrst_valid", 32'(bus.res_valid), 32'h0);
    check("midrst_data", 32'(bus.res_data), 32'h0);
    rst = 1'b0;
`ifdef GATE_ARB_PRIO0_EN
    bus.req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("prio_gnt%0d", c), 32'(bus.gnt), 32'h1);
      tick();
      check($sformatf("prio_id%0d", c), 32'(bus.res_id), 32'h0);
    end
`else
    bus.req = 4'b1010;
    #1;
    check("midrst_first_gnt", 32'(bus.gnt), 32'h2);
    tick();
    check("midrst_first_id", 32'(bus.res_id), 32'h1);
    #1;
    check("midrst_second_gnt", 32'(bus.gnt), 32'h8);
`endif
    bus.req = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
